// File: rtl/fifo_sample_reader_if.sv
// Read-side FIFO port plus sample stream outputs of the sample reader.
interface fifo_sample_reader_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int UFLOW_CNT_W = 8
);
   logic                   en_i;
   logic                   empty_i;
   logic [DATA_WIDTH-1:0]  data_i;
   logic                   re_o;
   logic [DATA_WIDTH-1:0]  sample_o;
   logic                   sample_valid_o;
   logic                   underflow_o;
   logic [UFLOW_CNT_W-1:0] uflow_count_o;
   logic                   primed_o;

   modport master (
      input  en_i, empty_i, data_i,
      output re_o, sample_o, sample_valid_o, underflow_o, uflow_count_o, primed_o
   );

   modport slave (
      output en_i, empty_i, data_i,
      input  re_o, sample_o, sample_valid_o, underflow_o, uflow_count_o, primed_o
   );
endinterface

// File: rtl/fifo_sample_reader.sv
// Drains the sample FIFO through a one-word prefetch buffer and releases one
// sample every TICK_DIV read-clock cycles, flagging ticks that find no data.
module fifo_sample_reader #(
   parameter int DATA_WIDTH  = 16,
   parameter int TICK_DIV    = 4,
   parameter int UFLOW_CNT_W = 8
) (
   input logic                  clk_rd_i,
   input logic                  rst_i,
   fifo_sample_reader_if.master bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [DATA_WIDTH-1:0]  buf_q, buf_d;
   logic                   buf_valid_q, buf_valid_d;
   logic                   inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0]  sample_q, sample_d;
   logic                   sample_valid_q, sample_valid_d;
   logic                   underflow_q, underflow_d;
   logic [UFLOW_CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;

   logic tick, consume, bypass, starve, want_read, re;

   function automatic logic [UFLOW_CNT_W-1:0] sat_inc(input logic [UFLOW_CNT_W-1:0] v);
      return (&v) ? v : v + UFLOW_CNT_W'(1);
   endfunction

   assign tick      = (state_q == RUN) && (tick_q == TICK_LAST);
   assign consume   = tick && buf_valid_q;
   assign bypass    = tick && !buf_valid_q && inflight_q;
   assign starve    = tick && !buf_valid_q && !inflight_q;
   assign want_read = (state_q != IDLE) && !inflight_q && (!buf_valid_q || consume);
   assign re        = want_read && !bus.empty_i;

   always_comb begin
      state_d        = state_q;
      tick_d         = '0;
      buf_d          = buf_q;
      buf_valid_d    = buf_valid_q;
      inflight_d     = re;
      sample_d       = sample_q;
      sample_valid_d = tick;
      underflow_d    = starve;
      uflow_cnt_d    = uflow_cnt_q;

      if (consume)     sample_d = buf_q;
      else if (bypass) sample_d = bus.data_i;
      if (starve)      uflow_cnt_d = sat_inc(uflow_cnt_q);

      // A returning word that was not forwarded straight out lands in the buffer.
      if (inflight_q && !bypass) begin
         buf_d       = bus.data_i;
         buf_valid_d = 1'b1;
      end else if (consume) begin
         buf_valid_d = 1'b0;
      end

      if (state_q == RUN) tick_d = tick ? '0 : tick_q + TW'(1);

      case (state_q)
         IDLE:    if (bus.en_i) state_d = PRIME;
         PRIME:   if (inflight_q) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = IDLE;
      endcase

      // Disable flushes the prefetch path; any word already popped is dropped.
      if ((state_q != IDLE) && !bus.en_i) begin
         state_d     = IDLE;
         buf_valid_d = 1'b0;
         inflight_d  = 1'b0;
         tick_d      = '0;
      end
   end

   always_ff @(posedge clk_rd_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         tick_q         <= '0;
         buf_valid_q    <= 1'b0;
         inflight_q     <= 1'b0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         underflow_q    <= 1'b0;
         uflow_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         tick_q         <= tick_d;
         buf_valid_q    <= buf_valid_d;
         inflight_q     <= inflight_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         underflow_q    <= underflow_d;
         uflow_cnt_q    <= uflow_cnt_d;
      end
   end

   always_ff @(posedge clk_rd_i) begin
      buf_q <= buf_d;
   end

   assign bus.re_o           = re;
   assign bus.sample_o       = sample_q;
   assign bus.sample_valid_o = sample_valid_q;
   assign bus.underflow_o    = underflow_q;
   assign bus.uflow_count_o  = uflow_cnt_q;
   assign bus.primed_o       = (state_q == RUN);
endmodule
